// File: rtl/sda_link_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sda_link_pkg
//  Purpose  : Definitions shared by both ends of the two-wire scl/sda nibble
//             link. Holds the default payload width, the bus levels that
//             mark START/STOP, and the receiver state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package sda_link_pkg;

    // Default number of data bits per frame, sent MSB first.
    localparam int c_NBITS_DEFAULT = 4;

    // Level of an idle (released) bus line; the board pulls both lines up.
    localparam logic c_BUS_IDLE = 1'b1;

    // START is sda falling to this level while scl is high,
    // STOP is sda rising to this level while scl is high.
    localparam logic c_SDA_START_LEVEL = 1'b0;
    localparam logic c_SDA_STOP_LEVEL  = 1'b1;

    // Receiver state encoding.
    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_RECV      = 2'd1;
    localparam logic [1:0] c_WAIT_STOP = 2'd2;

endpackage : sda_link_pkg
`default_nettype wire

// File: rtl/bit_sync.sv
`default_nettype none
// ============================================================================
//  Module   : bit_sync
//  Purpose  : Multi-flop synchronizer that brings one asynchronous bus line
//             into the local clock domain. Flops reset to the idle bus level
//             so that leaving reset never looks like a bus edge.
//  Ports    : clk  in  1  local clock
//             rst  in  1  asynchronous active-low reset
//             i_d  in  1  asynchronous input line
//             o_q  out 1  synchronized line
//  Revision : 1.0 - initial release
// ============================================================================
module bit_sync
    import sda_link_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_d,
    output logic      o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= {SYNC_STAGES{c_BUS_IDLE}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule : bit_sync
`default_nettype wire

// File: rtl/sdat_rx.sv
`default_nettype none
// ============================================================================
//  Module   : sdat_rx
//  Purpose  : Receiver for the two-wire scl/sda nibble link. Oversamples the
//             bus, detects START/STOP/scl-rise, shifts in NBITS data bits MSB
//             first and, on a well-formed frame, presents the nibble plus a
//             one-hot decode of it.
//  Ports    : sclk       in  1      local clock (>=4x bus toggle rate)
//             rst        in  1      asynchronous active-low reset
//             scl        in  1      bus clock (asynchronous)
//             sda        in  1      bus data (asynchronous, pulled up)
//             data_out   out NBITS  last good nibble
//             outhigh    out OUT_W  one-hot of data_out (all 0 after reset)
//             valid      out 1      1-cycle pulse on data_out/outhigh update
//             frame_err  out 1      1-cycle pulse on a malformed frame
//             busy       out 1      high from START until the frame ends
//  Revision : 1.0 - initial release
// ============================================================================
module sdat_rx
    import sda_link_pkg::*;
#(
    parameter int NBITS       = c_NBITS_DEFAULT,
    parameter int OUT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic             sclk,
    input  wire logic             rst,
    input  wire logic             scl,
    input  wire logic             sda,
    output logic [NBITS-1:0]      data_out,
    output logic [OUT_W-1:0]      outhigh,
    output logic                  valid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int                 c_CNT_W    = $clog2(NBITS + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(NBITS - 1);
    localparam logic [OUT_W-1:0]   c_ONE      = OUT_W'(1);

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic w_scl_s;
    logic w_sda_s;

    bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_scl (
        .clk (sclk),
        .rst (rst),
        .i_d (scl),
        .o_q (w_scl_s)
    );

    bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sda (
        .clk (sclk),
        .rst (rst),
        .i_d (sda),
        .o_q (w_sda_s)
    );

    // ------------------------------------------------------------------
    // Edge detection. START/STOP need scl high in both samples, so a sample
    // where scl and sda move together only ever yields the scl edge.
    // ------------------------------------------------------------------
    logic r_scl_prev;
    logic r_sda_prev;
    logic w_start;
    logic w_stop;
    logic w_rise;
    logic r_start;
    logic r_stop;
    logic r_rise;

    assign w_start = w_scl_s & r_scl_prev &  r_sda_prev & ~w_sda_s;
    assign w_stop  = w_scl_s & r_scl_prev & ~r_sda_prev &  w_sda_s;
    assign w_rise  = ~r_scl_prev & w_scl_s;

    // Events are registered once before the FSM acts on them. In the cycle
    // an event flag is high, r_sda_prev holds the sda sample that produced
    // it, which is the data bit for a registered rise.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            r_scl_prev <= c_BUS_IDLE;
            r_sda_prev <= c_BUS_IDLE;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
            r_rise     <= 1'b0;
        end else begin
            r_scl_prev <= w_scl_s;
            r_sda_prev <= w_sda_s;
            r_start    <= w_start;
            r_stop     <= w_stop;
            r_rise     <= w_rise;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM with shift/count and registered outputs
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [NBITS-1:0]   r_shift;
    logic [NBITS-1:0]   r_data;
    logic [OUT_W-1:0]   r_onehot;
    logic               r_valid;
    logic               r_err;
    logic               r_busy;

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_data   <= '0;
            r_onehot <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (r_start) begin
                        r_state <= c_RECV;
                        r_cnt   <= '0;
                        r_shift <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                c_RECV: begin
                    if (r_start) begin
                        // Repeated START simply begins the frame again.
                        r_cnt   <= '0;
                        r_shift <= '0;
                    end else if (r_stop) begin
                        // Any STOP here arrives before all bits are in.
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end else if (r_rise) begin
                        r_shift <= {r_shift[NBITS-2:0], r_sda_prev};
                        r_cnt   <= r_cnt + c_CNT_W'(1);
                        if (r_cnt == c_CNT_LAST) begin
                            r_state <= c_WAIT_STOP;
                        end
                    end
                end

                c_WAIT_STOP: begin
                    // Rises here are the transmitter's pre-stop low bit and
                    // are dropped; the shift register never overflows.
                    if (r_stop) begin
                        r_data   <= r_shift;
                        r_onehot <= c_ONE << r_shift;
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= c_IDLE;
                    end else if (r_start) begin
                        r_err   <= 1'b1;
                        r_cnt   <= '0;
                        r_shift <= '0;
                        r_state <= c_RECV;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign data_out  = r_data;
    assign outhigh   = r_onehot;
    assign valid     = r_valid;
    assign frame_err = r_err;
    assign busy      = r_busy;

endmodule : sdat_rx
`default_nettype wire

// File: tb/tb_sdat_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdat_rx
//  Purpose  : Self-checking bench for sdat_rx. Drives the bus as an
//             open-drain transmitter with an explicit pull-up on sda, keeps a
//             bus-level behavioural model of the link, compares every cycle
//             and pins key results with literal expectations.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sdat_rx;

    localparam int NB  = 4;
    localparam int OW  = 16;
    localparam int SS  = 2;
    // Samples between the bus being sampled and the outputs reflecting it.
    localparam int LAT = SS + 1;

    typedef struct packed {
        logic [NB-1:0] d;
        logic [OW-1:0] oh;
        logic          vld;
        logic          err;
        logic          bsy;
    } exp_t;

    logic          sclk;
    logic          rst;
    logic          scl_drv;
    logic          sda_pull_low;
    wire           scl_line = scl_drv;
    // Open-drain sda: released line reads 1 through the pull-up.
    wire           sda_line = sda_pull_low ? 1'b0 : 1'b1;
    logic [NB-1:0] data_out;
    logic [OW-1:0] outhigh;
    logic          valid;
    logic          frame_err;
    logic          busy;

    int n_pass  = 0;
    int n_total = 0;
    int n_valid = 0;
    int n_err   = 0;
    int n_busy  = 0;
    logic [OW-1:0] vlog[$];

    logic cur_scl = 1'b1;
    logic cur_sda = 1'b1;

    sdat_rx #(
        .NBITS       (NB),
        .OUT_W       (OW),
        .SYNC_STAGES (SS)
    ) dut (
        .sclk      (sclk),
        .rst       (rst),
        .scl       (scl_line),
        .sda       (sda_line),
        .data_out  (data_out),
        .outhigh   (outhigh),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // ------------------------------------------------------------------
    // Behavioural model: interprets the raw bus samples as frames and
    // delays its outputs by the receiver latency.
    // ------------------------------------------------------------------
    exp_t          exp_q[$];
    exp_t          cur_exp = '0;
    logic [NB-1:0] m_data;
    logic [OW-1:0] m_oh;
    logic          m_in;
    logic          m_bits[$];
    logic          m_pscl;
    logic          m_psda;
    int            m_commits = 0;

    always @(posedge sclk) begin
        logic sc, sd, ev_st, ev_sp, ev_rs;
        exp_t nx;
        int   val;
        if (!rst) begin
            m_data = '0;
            m_oh   = '0;
            m_in   = 1'b0;
            m_bits = {};
            m_pscl = 1'b1;
            m_psda = 1'b1;
            exp_q  = {};
            for (int i = 0; i < LAT; i++) exp_q.push_back('0);
            cur_exp = '0;
        end else begin
            sc = scl_line;
            sd = sda_line;
            ev_st = sc && m_pscl && m_psda && !sd;
            ev_sp = sc && m_pscl && !m_psda && sd;
            ev_rs = sc && !m_pscl;
            nx = '0;
            if (ev_st) begin
                if (m_in && m_bits.size() == NB) nx.err = 1'b1;
                m_in   = 1'b1;
                m_bits = {};
            end else if (ev_sp && m_in) begin
                if (m_bits.size() == NB) begin
                    val = 0;
                    foreach (m_bits[i]) val = val * 2 + int'(m_bits[i]);
                    m_data = NB'(val);
                    m_oh   = '0;
                    m_oh[val] = 1'b1;
                    nx.vld = 1'b1;
                    m_commits++;
                end else begin
                    nx.err = 1'b1;
                end
                m_in   = 1'b0;
                m_bits = {};
            end else if (ev_rs && m_in && m_bits.size() < NB) begin
                m_bits.push_back(sd);
            end
            nx.d   = m_data;
            nx.oh  = m_oh;
            nx.bsy = m_in;
            exp_q.push_back(nx);
            cur_exp = exp_q.pop_front();
            m_pscl  = sc;
            m_psda  = sd;
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare against the model (zeros while in reset)
    // ------------------------------------------------------------------
    always @(negedge sclk) begin
        exp_t a, e;
        a = {data_out, outhigh, valid, frame_err, busy};
        e = rst ? cur_exp : exp_t'('0);
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL cycle_cmp t=%0t dut=%h model=%h", $time, a, e);
        if (rst) begin
            if (valid) begin
                n_valid++;
                vlog.push_back(outhigh);
            end
            if (frame_err) n_err++;
            if (busy) n_busy++;
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    // Each bus level is held 4..6 local cycles; changes land 2ns after an edge.
    task automatic set_bus(input logic c, input logic d);
        scl_drv      = c;
        sda_pull_low = !d;
        cur_scl      = c;
        cur_sda      = d;
        repeat ($urandom_range(4, 6)) @(posedge sclk);
        #2;
    endtask

    task automatic do_start();
        if (!(cur_scl && cur_sda)) begin
            if (cur_scl) set_bus(1'b0, cur_sda);
            set_bus(1'b0, 1'b1);
            set_bus(1'b1, 1'b1);
        end
        set_bus(1'b1, 1'b0);
    endtask

    // Data set while scl low, sampled on scl rise; scl left high.
    task automatic do_bit(input logic b);
        set_bus(1'b0, cur_sda);
        set_bus(1'b0, b);
        set_bus(1'b1, b);
    endtask

    // Pre-stop low bit, then sda released while scl high.
    task automatic do_stop();
        if (cur_scl) set_bus(1'b0, cur_sda);
        set_bus(1'b0, 1'b0);
        set_bus(1'b1, 1'b0);
        set_bus(1'b1, 1'b1);
        set_bus(1'b1, 1'b1);
    endtask

    task automatic send_frame(input logic [NB-1:0] v);
        do_start();
        for (int i = NB - 1; i >= 0; i--) do_bit(v[i]);
        do_stop();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int v0, e0, b0, q0, lat;
        logic [NB-1:0] rv;
        rst          = 1'b0;
        scl_drv      = 1'b1;
        sda_pull_low = 1'b0;
        repeat (3) @(posedge sclk);
        #2;
        check("rst_data",    32'(data_out), 32'h0);
        check("rst_outhigh", 32'(outhigh), 32'h0);
        check("rst_flags",   32'({valid, frame_err, busy}), 32'h0);
        rst = 1'b1;
        set_bus(1'b1, 1'b1);

        // 1: frame 1010 with STOP-to-valid latency measurement
        v0 = n_valid; e0 = n_err;
        do_start();
        do_bit(1'b1); do_bit(1'b0); do_bit(1'b1); do_bit(1'b0);
        set_bus(1'b0, 1'b0);
        set_bus(1'b0, 1'b0);
        set_bus(1'b1, 1'b0);
        sda_pull_low = 1'b0;
        cur_sda      = 1'b1;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge sclk);
            #1;
            if (valid && lat == 0) lat = k;
        end
        check("t1_latency", 32'(lat), 32'(SS + 2));
        set_bus(1'b1, 1'b1);
        check("t1_valid_cnt", 32'(n_valid - v0), 32'd1);
        check("t1_data",      32'(data_out), 32'hA);
        check("t1_outhigh",   32'(outhigh), 32'h0400);
        check("t1_model_oh",  32'(cur_exp.oh), 32'h0400);
        check("t1_no_err",    32'(n_err - e0), 32'd0);

        // 2: 0x0 then 0xF back to back
        v0 = n_valid; q0 = vlog.size();
        send_frame(4'h0);
        send_frame(4'hF);
        check("t2_valid_cnt", 32'(n_valid - v0), 32'd2);
        check("t2_oh_first",  (vlog.size() > q0)     ? 32'(vlog[q0])     : 32'hDEAD, 32'h0001);
        check("t2_oh_second", (vlog.size() > q0 + 1) ? 32'(vlog[q0 + 1]) : 32'hDEAD, 32'h8000);

        // 3: short frame -> error, output held
        v0 = n_valid; e0 = n_err;
        do_start();
        do_bit(1'b1); do_bit(1'b0);
        do_stop();
        check("t3_err_cnt",   32'(n_err - e0), 32'd1);
        check("t3_no_valid",  32'(n_valid - v0), 32'd0);
        check("t3_data_held", 32'(data_out), 32'hF);
        check("t3_oh_held",   32'(outhigh), 32'h8000);
        check("t3_busy_low",  32'(busy), 32'd0);

        // 4: repeated START after 3 bits, then 0110
        v0 = n_valid; e0 = n_err;
        do_start();
        do_bit(1'b1); do_bit(1'b0); do_bit(1'b1);
        do_start();
        do_bit(1'b0); do_bit(1'b1); do_bit(1'b1); do_bit(1'b0);
        do_stop();
        check("t4_no_err",    32'(n_err - e0), 32'd0);
        check("t4_valid_cnt", 32'(n_valid - v0), 32'd1);
        check("t4_data",      32'(data_out), 32'h6);
        check("t4_outhigh",   32'(outhigh), 32'h0040);

        // 5: reset mid-frame, then 0x3
        do_start();
        do_bit(1'b1); do_bit(1'b1);
        #1;
        rst = 1'b0;
        #1;
        check("t5_rst_data", 32'(data_out), 32'h0);
        check("t5_rst_oh",   32'(outhigh), 32'h0);
        check("t5_rst_flag", 32'({valid, frame_err, busy}), 32'h0);
        set_bus(1'b1, 1'b1);
        set_bus(1'b1, 1'b1);
        rst = 1'b1;
        set_bus(1'b1, 1'b1);
        v0 = n_valid;
        send_frame(4'h3);
        check("t5_valid_cnt", 32'(n_valid - v0), 32'd1);
        check("t5_outhigh",   32'(outhigh), 32'h0008);

        // 6: sda toggles with scl low, simultaneous scl+sda changes
        v0 = n_valid; e0 = n_err; b0 = n_busy;
        set_bus(1'b0, 1'b1);
        set_bus(1'b0, 1'b0);
        set_bus(1'b0, 1'b1);
        set_bus(1'b1, 1'b0);
        set_bus(1'b0, 1'b0);
        set_bus(1'b1, 1'b1);
        set_bus(1'b1, 1'b1);
        check("t6_no_busy",  32'(n_busy - b0), 32'd0);
        check("t6_no_valid", 32'(n_valid - v0), 32'd0);
        check("t6_no_err",   32'(n_err - e0), 32'd0);

        // Randomized frames: good, short, restarted and unterminated
        for (int r = 0; r < 40; r++) begin
            rv = NB'($urandom_range(0, 15));
            case ($urandom_range(0, 4))
                0, 1: send_frame(rv);
                2: begin
                    do_start();
                    for (int i = 0; i < int'($urandom_range(0, 3)); i++)
                        do_bit(1'($urandom_range(0, 1)));
                    do_stop();
                end
                3: begin
                    do_start();
                    for (int i = 0; i < int'($urandom_range(1, 3)); i++)
                        do_bit(1'($urandom_range(0, 1)));
                    send_frame(rv);
                end
                default: begin
                    // Full frame followed by START instead of STOP.
                    do_start();
                    for (int i = NB - 1; i >= 0; i--) do_bit(rv[i]);
                    set_bus(1'b0, cur_sda);
                    set_bus(1'b0, 1'b1);
                    set_bus(1'b1, 1'b1);
                    set_bus(1'b1, 1'b0);
                    for (int i = NB - 1; i >= 0; i--) do_bit(~rv[i]);
                    do_stop();
                end
            endcase
        end
        set_bus(1'b1, 1'b1);
        check("rand_commits", 32'(n_valid), 32'(m_commits));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_sdat_rx
`default_nettype wire
